mem_tid_arbiter: RTL and testbench



---
 rtl/mem_tid_arbiter_pkg.sv | 18 +
 rtl/mem_tid_arbiter_rr.sv | 32 +++
 rtl/mem_tid_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_tid_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tid_arbiter_pkg.sv
// Shared types for the memory transaction-ID arbiter: TID table entry and requester indices.
package mem_tid_arbiter_pkg;

  localparam int unsigned OWNER_W = 2;

  typedef enum int unsigned {
    REQ_ICACHE = 0,
    REQ_DLOAD  = 1,
    REQ_DSTORE = 2
  } req_idx_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               store;
  } tid_entry_t;

endpackage

// File: rtl/mem_tid_arbiter_rr.sv
// Round-robin arbiter over a pre-filtered eligibility mask; search starts at ptr.
module rr_arb_masked #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic [IW-1:0] next_ptr
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
    next_ptr = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
  end

endmodule

// File: rtl/mem_tid_arbiter.sv
// Shares one memory request port among requesters, allocates transaction IDs and
// routes responses back to the owning requester.
module mem_tid_arbiter
  import mem_tid_arbiter_pkg::*;
#(
  parameter int unsigned NumReq               = 3,
  parameter int unsigned MemTidWidth          = 2,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned AddrWidth            = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_store_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [AddrWidth-1:0]        mem_req_addr_o,
  output logic [MemTidWidth-1:0]      mem_req_tid_o,
  output logic                        mem_req_store_o,
  input  logic                        mem_rsp_valid_i,
  input  logic [MemTidWidth-1:0]      mem_rsp_tid_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic                        tid_err_o,
  output logic                        busy_o
);

  localparam int unsigned NumTid = 1 << MemTidWidth;
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned ScW    = $clog2(MaxOutstandingStores + 1);
  localparam logic [ScW-1:0] StoreCap = ScW'(MaxOutstandingStores);

  tid_entry_t               tid_table [NumTid];
  logic [NumTid-1:0]        tid_busy;
  logic [MemTidWidth-1:0]   free_tid;
  logic                     any_free;
  logic [ScW-1:0]           store_cnt;
  logic [IdxW-1:0]          rr_ptr, rr_next, winner;
  logic [NumReq-1:0]        eligible, grant;
  logic                     stage_load, granted, win_store;
  logic [AddrWidth-1:0]     win_addr;
  tid_entry_t               rsp_entry;
  logic                     rsp_hit, st_inc, st_dec;

  always_comb begin
    tid_busy = '0;
    any_free = 1'b0;
    free_tid = '0;
    for (int unsigned i = 0; i < NumTid; i++) begin
      tid_busy[i] = tid_table[i].valid;
      if (!any_free && !tid_table[i].valid) begin
        any_free = 1'b1;
        free_tid = MemTidWidth'(i);
      end
    end
  end

  // Grants are suppressed while reset is held so every output reads 0 during reset.
  always_comb begin
    stage_load = !mem_req_valid_o || mem_req_ready_i;
    eligible   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      eligible[i] = !rst_i && req_valid_i[i] && stage_load && any_free &&
                    (!req_store_i[i] || (store_cnt < StoreCap));
    end
  end

  rr_arb_masked #(.N(NumReq)) u_rr (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .winner   (winner),
    .next_ptr (rr_next)
  );

  always_comb begin
    granted     = |grant;
    req_ready_o = grant;
    win_store   = req_store_i[winner];
    win_addr    = req_addr_i[32'(winner)*AddrWidth +: AddrWidth];
    rsp_entry   = tid_table[mem_rsp_tid_i];
    rsp_hit     = mem_rsp_valid_i && rsp_entry.valid;
    tid_err_o   = !rst_i && mem_rsp_valid_i && !rsp_entry.valid;
    rsp_valid_o = '0;
    if (rsp_hit) rsp_valid_o[rsp_entry.owner] = 1'b1;
    st_inc      = granted && win_store;
    st_dec      = rsp_hit && rsp_entry.store;
    busy_o      = (|tid_busy) || mem_req_valid_o;
  end

  // The freed entry and the allocated entry never coincide: free_tid only sees
  // entries that were already free before this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumTid; i++) tid_table[i] <= '0;
      store_cnt       <= '0;
      rr_ptr          <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_tid_o   <= '0;
      mem_req_store_o <= 1'b0;
    end else begin
      if (rsp_hit) tid_table[mem_rsp_tid_i] <= '0;
      if (granted) begin
        tid_table[free_tid] <= '{valid: 1'b1, owner: OWNER_W'(winner), store: win_store};
        rr_ptr              <= rr_next;
      end
      case ({st_inc, st_dec})
        2'b10:   store_cnt <= store_cnt + 1'b1;
        2'b01:   store_cnt <= store_cnt - 1'b1;
        default: store_cnt <= store_cnt;
      endcase
      if (granted) begin
        mem_req_valid_o <= 1'b1;
        mem_req_addr_o  <= win_addr;
        mem_req_tid_o   <= free_tid;
        mem_req_store_o <= win_store;
      end else if (mem_req_ready_i) begin
        mem_req_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(req_ready_o));
      assert (!(granted && tid_busy[free_tid]));
      assert (store_cnt <= StoreCap);
    end
  end

endmodule

// File: tb/tb_mem_tid_arbiter.sv
// Directed bench: default instance for routing/RR/backpressure/error, wide-TID instance for the store cap.
module tb_mem_tid_arbiter;
  import mem_tid_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]   a_req_valid, a_req_store, a_req_ready, a_rsp_valid;
  logic [191:0] a_req_addr;
  logic         a_mem_req_valid, a_mem_req_ready, a_mem_req_store, a_mem_rsp_valid, a_tid_err, a_busy;
  logic [63:0]  a_mem_req_addr;
  logic [1:0]   a_mem_req_tid, a_mem_rsp_tid;

  logic [2:0]   b_req_valid, b_req_store, b_req_ready, b_rsp_valid;
  logic [191:0] b_req_addr;
  logic         b_mem_req_valid, b_mem_req_ready, b_mem_req_store, b_mem_rsp_valid, b_tid_err, b_busy;
  logic [63:0]  b_mem_req_addr;
  logic [3:0]   b_mem_req_tid, b_mem_rsp_tid;

  mem_tid_arbiter u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_store_i(a_req_store), .req_addr_i(a_req_addr),
    .req_ready_o(a_req_ready),
    .mem_req_valid_o(a_mem_req_valid), .mem_req_ready_i(a_mem_req_ready),
    .mem_req_addr_o(a_mem_req_addr), .mem_req_tid_o(a_mem_req_tid), .mem_req_store_o(a_mem_req_store),
    .mem_rsp_valid_i(a_mem_rsp_valid), .mem_rsp_tid_i(a_mem_rsp_tid),
    .rsp_valid_o(a_rsp_valid), .tid_err_o(a_tid_err), .busy_o(a_busy)
  );

  mem_tid_arbiter #(
    .NumReq(3), .MemTidWidth(4), .MaxOutstandingStores(7), .AddrWidth(64)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_store_i(b_req_store), .req_addr_i(b_req_addr),
    .req_ready_o(b_req_ready),
    .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(b_mem_req_ready),
    .mem_req_addr_o(b_mem_req_addr), .mem_req_tid_o(b_mem_req_tid), .mem_req_store_o(b_mem_req_store),
    .mem_rsp_valid_i(b_mem_rsp_valid), .mem_rsp_tid_i(b_mem_rsp_tid),
    .rsp_valid_o(b_rsp_valid), .tid_err_o(b_tid_err), .busy_o(b_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_a_addr(input int unsigned idx, input logic [63:0] v);
    a_req_addr[idx*64 +: 64] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a_req_valid = '0; a_req_store = '0; a_req_addr = '0; a_mem_req_ready = 1'b0;
    a_mem_rsp_valid = 1'b0; a_mem_rsp_tid = '0;
    b_req_valid = '0; b_req_store = '0; b_req_addr = '0; b_mem_req_ready = 1'b0;
    b_mem_rsp_valid = 1'b0; b_mem_rsp_tid = '0;
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_ready", a_req_ready, 3'b000);
    check("rst_mvalid", a_mem_req_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_rsp", a_rsp_valid, 3'b000);
    check("rst_err", a_tid_err, 1'b0);
    check("rst_busy_b", b_busy, 1'b0);
    rst = 1'b0;
    #1;

    // Single request
    set_a_addr(REQ_ICACHE, 64'h8000_0000);
    a_req_valid = 3'b001; a_mem_req_ready = 1'b1;
    #1 check("t1_ready", a_req_ready, 3'b001);
    tick();
    a_req_valid = 3'b000;
    #1;
    check("t1_mvalid", a_mem_req_valid, 1'b1);
    check("t1_tid", a_mem_req_tid, 2'd0);
    check("t1_addr", a_mem_req_addr, 64'h8000_0000);
    check("t1_store", a_mem_req_store, 1'b0);
    tick();
    check("t1_drained", a_mem_req_valid, 1'b0);
    check("t1_busy_inflight", a_busy, 1'b1);
    a_mem_rsp_valid = 1'b1; a_mem_rsp_tid = 2'd0;
    #1;
    check("t1_rsp", a_rsp_valid, 3'b001);
    check("t1_err", a_tid_err, 1'b0);
    tick();
    a_mem_rsp_valid = 1'b0;
    #1 check("t1_idle", a_busy, 1'b0);

    // Round-robin, pool exhaustion, simultaneous grant and response
    do_reset();
    set_a_addr(REQ_ICACHE, 64'h1000); set_a_addr(REQ_DLOAD, 64'h2000); set_a_addr(REQ_DSTORE, 64'h3000);
    a_req_valid = 3'b111; a_req_store = 3'b000; a_mem_req_ready = 1'b1;
    #1 check("rr_g0", a_req_ready, 3'b001);
    tick();
    check("rr_g1", a_req_ready, 3'b010);
    check("rr_tid0", a_mem_req_tid, 2'd0);
    check("rr_addr0", a_mem_req_addr, 64'h1000);
    tick();
    check("rr_g2", a_req_ready, 3'b100);
    check("rr_tid1", a_mem_req_tid, 2'd1);
    check("rr_addr1", a_mem_req_addr, 64'h2000);
    tick();
    a_mem_rsp_valid = 1'b1; a_mem_rsp_tid = 2'd1;
    #1;
    check("rr_g3", a_req_ready, 3'b001);
    check("rr_tid2", a_mem_req_tid, 2'd2);
    check("rr_addr2", a_mem_req_addr, 64'h3000);
    check("sim_rsp", a_rsp_valid, 3'b010);
    tick();
    a_mem_rsp_valid = 1'b0;
    #1;
    check("sim_reuse_next", a_req_ready, 3'b010);
    check("rr_tid3", a_mem_req_tid, 2'd3);
    check("rr_addr3", a_mem_req_addr, 64'h1000);
    tick();
    check("full_g", a_req_ready, 3'b000);
    check("full_tid", a_mem_req_tid, 2'd1);
    check("full_addr", a_mem_req_addr, 64'h2000);
    a_mem_rsp_valid = 1'b1; a_mem_rsp_tid = 2'd0;
    #1;
    check("full_rsp", a_rsp_valid, 3'b001);
    check("full_no_same_cycle", a_req_ready, 3'b000);
    tick();
    a_mem_rsp_valid = 1'b0;
    #1;
    check("full_freed_g", a_req_ready, 3'b100);
    check("full_mvalid", a_mem_req_valid, 1'b0);
    tick();
    a_req_valid = 3'b000;
    #1;
    check("full_tid_reuse", a_mem_req_tid, 2'd0);
    check("full_addr_reuse", a_mem_req_addr, 64'h3000);

    // Backpressure
    do_reset();
    set_a_addr(REQ_ICACHE, 64'hA000); set_a_addr(REQ_DLOAD, 64'hB000);
    a_mem_req_ready = 1'b0; a_req_valid = 3'b001;
    #1 check("bp_g0", a_req_ready, 3'b001);
    tick();
    a_req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready", a_req_ready, 3'b000);
      check("bp_mvalid", a_mem_req_valid, 1'b1);
      check("bp_addr", a_mem_req_addr, 64'hA000);
      check("bp_tid", a_mem_req_tid, 2'd0);
      tick();
    end
    a_mem_req_ready = 1'b1;
    #1 check("bp_drain_grant", a_req_ready, 3'b010);
    tick();
    a_req_valid = 3'b000;
    #1;
    check("bp_next_addr", a_mem_req_addr, 64'hB000);
    check("bp_next_tid", a_mem_req_tid, 2'd1);
    check("bp_next_valid", a_mem_req_valid, 1'b1);

    // Unallocated response and asynchronous reset
    do_reset();
    a_mem_rsp_valid = 1'b1; a_mem_rsp_tid = 2'd3;
    #1;
    check("err_pulse", a_tid_err, 1'b1);
    check("err_no_route", a_rsp_valid, 3'b000);
    tick();
    a_mem_rsp_valid = 1'b0;
    #1;
    check("err_clear", a_tid_err, 1'b0);
    check("err_no_state", a_busy, 1'b0);
    a_mem_req_ready = 1'b1; a_req_valid = 3'b011;
    tick(); tick();
    a_req_valid = 3'b000; a_mem_req_ready = 1'b0;
    #1;
    check("inflight_busy", a_busy, 1'b1);
    check("inflight_tid", a_mem_req_tid, 2'd1);
    rst = 1'b1;
    #1;
    check("async_busy", a_busy, 1'b0);
    check("async_mvalid", a_mem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    a_mem_rsp_valid = 1'b1; a_mem_rsp_tid = 2'd0;
    #1;
    check("late_err", a_tid_err, 1'b1);
    check("late_rsp", a_rsp_valid, 3'b000);
    tick();
    a_mem_rsp_valid = 1'b0;

    // Store cap on the 16-ID instance
    do_reset();
    b_req_addr[REQ_DSTORE*64 +: 64] = 64'hC000;
    b_req_addr[REQ_DLOAD*64 +: 64]  = 64'hD000;
    b_mem_req_ready = 1'b1; b_req_store = 3'b100; b_req_valid = 3'b100;
    for (int i = 0; i < 7; i++) begin
      #1 check("sc_grant", b_req_ready, 3'b100);
      tick();
    end
    check("sc_tid6", b_mem_req_tid, 4'd6);
    check("sc_store", b_mem_req_store, 1'b1);
    check("sc_addr", b_mem_req_addr, 64'hC000);
    check("sc_blocked", b_req_ready, 3'b000);
    b_req_valid = 3'b110;
    #1 check("sc_load_ok", b_req_ready, 3'b010);
    tick();
    check("sc_load_tid", b_mem_req_tid, 4'd7);
    check("sc_load_store_bit", b_mem_req_store, 1'b0);
    b_req_valid = 3'b100; b_mem_rsp_valid = 1'b1; b_mem_rsp_tid = 4'd0;
    #1;
    check("sc_rsp", b_rsp_valid, 3'b100);
    check("sc_still_blocked", b_req_ready, 3'b000);
    check("sc_err", b_tid_err, 1'b0);
    tick();
    b_mem_rsp_valid = 1'b0;
    #1;
    check("sc_unblock", b_req_ready, 3'b100);
    check("sc_mvalid", b_mem_req_valid, 1'b0);
    tick();
    b_req_valid = 3'b000;
    #1 check("sc_reuse_tid", b_mem_req_tid, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
